alarm_timer_ctrl: RTL and testbench

Programmable countdown timer serving the anti-theft FSM. Holds the four reprogrammable time parameters (arm delay, driver delay, passenger delay, alarm-on) and loads the one selected by `interval` when `start_timer` pulses. Counts whole seconds from a clock prescaler and returns a single-cycle `expired` pulse. Sits between the anti-theft FSM and the user reprogramming switches/button.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/sec_prescaler.sv | 30 +++
 rtl/alarm_timer_ctrl.sv | 83 ++++++++
 tb/tb_alarm_timer_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared encodings and default time parameters for the anti-theft countdown timer.
package timer_pkg;

  localparam int unsigned VAL_W       = 4;
  localparam int unsigned T_ARM_DELAY = 6;
  localparam int unsigned T_DRIVER    = 8;
  localparam int unsigned T_PASS      = 15;
  localparam int unsigned T_ALARM_ON  = 10;

  typedef enum logic [1:0] {
    IV_ARM_DELAY = 2'b00,
    IV_DRIVER    = 2'b01,
    IV_PASS      = 2'b10,
    IV_ALARM_ON  = 2'b11
  } interval_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock into a one-cycle tick every CLK_HZ enabled cycles.
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Combinational so the owner acts on the same edge the counter wraps.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/alarm_timer_ctrl.sv
// Programmable seconds countdown with a reprogrammable 4-entry parameter table.
module alarm_timer_ctrl #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned VAL_W       = timer_pkg::VAL_W,
  parameter int unsigned T_ARM_DELAY = timer_pkg::T_ARM_DELAY,
  parameter int unsigned T_DRIVER    = timer_pkg::T_DRIVER,
  parameter int unsigned T_PASS      = timer_pkg::T_PASS,
  parameter int unsigned T_ALARM_ON  = timer_pkg::T_ALARM_ON
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       interval,
  input  logic             start_timer,
  input  logic             reprogram,
  input  logic [1:0]       param_sel,
  input  logic [VAL_W-1:0] param_val,
  output logic             expired,
  output logic             busy,
  output logic [VAL_W-1:0] remaining
);

  import timer_pkg::*;

  timer_state_e     state;
  logic [VAL_W-1:0] param_tbl [4];
  logic             tick;

  sec_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_timer),
    .enable  (state == RUN),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      busy                    <= 1'b0;
      expired                 <= 1'b0;
      remaining               <= '0;
      param_tbl[IV_ARM_DELAY] <= VAL_W'(T_ARM_DELAY);
      param_tbl[IV_DRIVER]    <= VAL_W'(T_DRIVER);
      param_tbl[IV_PASS]      <= VAL_W'(T_PASS);
      param_tbl[IV_ALARM_ON]  <= VAL_W'(T_ALARM_ON);
    end else begin
      expired <= 1'b0;

      // A same-edge load reads the pre-write table value.
      if (reprogram && (param_val != '0)) begin
        param_tbl[param_sel] <= param_val;
      end

      case (state)
        IDLE: begin
          if (start_timer) begin
            state     <= RUN;
            busy      <= 1'b1;
            remaining <= param_tbl[interval];
          end
        end
        RUN: begin
          if (start_timer) begin
            remaining <= param_tbl[interval];
          end else if (tick) begin
            if (remaining > VAL_W'(1)) begin
              remaining <= remaining - 1'b1;
            end else begin
              remaining <= '0;
              busy      <= 1'b0;
              expired   <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Directed self-checking bench for alarm_timer_ctrl with a 4-cycle second.
module tb_alarm_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] interval = 2'b00;
  logic       start_timer = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] param_sel = 2'b00;
  logic [3:0] param_val = 4'd0;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  int checks = 0;
  int failures = 0;

  logic       exp_e;
  logic       exp_b;
  logic [3:0] exp_r;

  alarm_timer_ctrl #(
    .CLK_HZ (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .interval    (interval),
    .start_timer (start_timer),
    .reprogram   (reprogram),
    .param_sel   (param_sel),
    .param_val   (param_val),
    .expired     (expired),
    .busy        (busy),
    .remaining   (remaining)
  );

  always #5 clk = ~clk;

  // One active edge, then settle on the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input logic [1:0] iv);
    interval    = iv;
    start_timer = 1'b1;
    cyc();
    start_timer = 1'b0;
  endtask

  task automatic write_param(input logic [1:0] sel, input logic [3:0] val);
    param_sel = sel;
    param_val = val;
    reprogram = 1'b1;
    cyc();
    reprogram = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if (expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0", expired); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (remaining !== 4'd0) begin failures++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_driver_countdown();
    start(2'b01);
    checks++;
    if (remaining !== 4'd8) begin failures++; $display("FAIL drv_load got=%0d exp=8", remaining); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL drv_busy_rise got=%b exp=1", busy); end
    for (int i = 1; i <= 40; i++) begin
      cyc();
      exp_e = (i == 32);
      exp_b = (i < 32);
      exp_r = (i < 32) ? 4'(8 - i / 4) : 4'd0;
      checks++;
      if (expired !== exp_e) begin failures++; $display("FAIL drv_expired i=%0d got=%b exp=%b", i, expired, exp_e); end
      checks++;
      if (busy !== exp_b) begin failures++; $display("FAIL drv_busy i=%0d got=%b exp=%b", i, busy, exp_b); end
      checks++;
      if (remaining !== exp_r) begin failures++; $display("FAIL drv_remaining i=%0d got=%0d exp=%0d", i, remaining, exp_r); end
    end
  endtask

  task automatic test_reprogram();
    write_param(2'b10, 4'd3);
    start(2'b10);
    checks++;
    if (remaining !== 4'd3) begin failures++; $display("FAIL reprog_load got=%0d exp=3", remaining); end
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        param_sel = 2'b10;
        param_val = 4'd0;
        reprogram = 1'b1;
      end
      cyc();
      reprogram = 1'b0;
      exp_e = (i == 12);
      exp_r = (i < 12) ? 4'(3 - i / 4) : 4'd0;
      checks++;
      if (expired !== exp_e) begin failures++; $display("FAIL reprog_expired i=%0d got=%b exp=%b", i, expired, exp_e); end
      checks++;
      if (remaining !== exp_r) begin failures++; $display("FAIL reprog_remaining i=%0d got=%0d exp=%0d", i, remaining, exp_r); end
    end
    start(2'b10);
    checks++;
    if (remaining !== 4'd3) begin failures++; $display("FAIL zero_write_ignored got=%0d exp=3", remaining); end
    for (int i = 1; i <= 14; i++) begin
      cyc();
      exp_e = (i == 12);
      checks++;
      if (expired !== exp_e) begin failures++; $display("FAIL reprog2_expired i=%0d got=%b exp=%b", i, expired, exp_e); end
    end
  endtask

  task automatic test_restart();
    start(2'b00);
    checks++;
    if (remaining !== 4'd6) begin failures++; $display("FAIL rst_load got=%0d exp=6", remaining); end
    for (int i = 1; i <= 9; i++) begin
      cyc();
      exp_r = 4'(6 - i / 4);
      checks++;
      if (remaining !== exp_r) begin failures++; $display("FAIL restart_pre_remaining i=%0d got=%0d exp=%0d", i, remaining, exp_r); end
    end
    start(2'b11);
    checks++;
    if (remaining !== 4'd10) begin failures++; $display("FAIL restart_load got=%0d exp=10", remaining); end
    for (int j = 1; j <= 44; j++) begin
      cyc();
      exp_e = (j == 40);
      exp_b = (j < 40);
      checks++;
      if (expired !== exp_e) begin failures++; $display("FAIL restart_expired j=%0d got=%b exp=%b", j, expired, exp_e); end
      checks++;
      if (busy !== exp_b) begin failures++; $display("FAIL restart_busy j=%0d got=%b exp=%b", j, busy, exp_b); end
    end
  endtask

  task automatic test_same_edge();
    param_sel   = 2'b01;
    param_val   = 4'd2;
    reprogram   = 1'b1;
    interval    = 2'b01;
    start_timer = 1'b1;
    cyc();
    reprogram   = 1'b0;
    start_timer = 1'b0;
    checks++;
    if (remaining !== 4'd8) begin failures++; $display("FAIL same_edge_load got=%0d exp=8", remaining); end
    for (int i = 1; i <= 34; i++) begin
      cyc();
      exp_e = (i == 32);
      checks++;
      if (expired !== exp_e) begin failures++; $display("FAIL same_edge_expired i=%0d got=%b exp=%b", i, expired, exp_e); end
    end
    start(2'b01);
    checks++;
    if (remaining !== 4'd2) begin failures++; $display("FAIL same_edge_next_load got=%0d exp=2", remaining); end
    for (int i = 1; i <= 10; i++) begin
      cyc();
      exp_e = (i == 8);
      checks++;
      if (expired !== exp_e) begin failures++; $display("FAIL same_edge_next_expired i=%0d got=%b exp=%b", i, expired, exp_e); end
    end
  endtask

  task automatic test_reset_mid();
    write_param(2'b10, 4'd3);
    start(2'b10);
    repeat (5) cyc();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++;
    if (remaining !== 4'd0) begin failures++; $display("FAIL mid_reset_remaining got=%0d exp=0", remaining); end
    checks++;
    if (expired !== 1'b0) begin failures++; $display("FAIL mid_reset_expired got=%b exp=0", expired); end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++;
      if (expired !== 1'b0) begin failures++; $display("FAIL mid_hold_expired i=%0d got=%b exp=0", i, expired); end
    end
    reset_n = 1'b1;
    cyc();
    start(2'b10);
    checks++;
    if (remaining !== 4'd15) begin failures++; $display("FAIL mid_default_load got=%0d exp=15", remaining); end
    for (int i = 1; i <= 62; i++) begin
      cyc();
      exp_e = (i == 60);
      checks++;
      if (expired !== exp_e) begin failures++; $display("FAIL mid_after_expired i=%0d got=%b exp=%b", i, expired, exp_e); end
    end
  endtask

  task automatic test_final_tick_restart();
    start(2'b00);
    for (int i = 1; i <= 23; i++) begin
      cyc();
      checks++;
      if (expired !== 1'b0) begin failures++; $display("FAIL ftr_pre_expired i=%0d got=%b exp=0", i, expired); end
    end
    checks++;
    if (remaining !== 4'd1) begin failures++; $display("FAIL ftr_pre_remaining got=%0d exp=1", remaining); end
    start(2'b01);
    checks++;
    if (expired !== 1'b0) begin failures++; $display("FAIL ftr_expired got=%b exp=0", expired); end
    checks++;
    if (remaining !== 4'd8) begin failures++; $display("FAIL ftr_reload got=%0d exp=8", remaining); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ftr_busy got=%b exp=1", busy); end
    for (int j = 1; j <= 34; j++) begin
      cyc();
      exp_e = (j == 32);
      checks++;
      if (expired !== exp_e) begin failures++; $display("FAIL ftr_after_expired j=%0d got=%b exp=%b", j, expired, exp_e); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_driver_countdown();
    test_reprogram();
    test_restart();
    test_same_edge();
    test_reset_mid();
    test_reset();
    test_final_tick_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
